// File: rtl/sad_pkg.sv
// Shared definitions for the full-search SAD engine.
//   - Pixel / SAD widths and block size.
//   - SAD_INIT: starting value of the running minimum (larger than any real SAD).
//   - state_t: FSM state encoding used by sad_min_search.
//   - abs_diff: |a - b| of two unsigned pixels, using a 9-bit signed difference.
package sad_pkg;

    localparam int PIX_W        = 8;
    localparam int SAD_W        = 16;
    localparam int BLOCK_PIXELS = 256;

    localparam logic [SAD_W-1:0] SAD_INIT = 16'hFFFF;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_FULL = 3'd1,
        ST_READ      = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_COMPARE   = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                  input logic [PIX_W-1:0] b);
        logic [PIX_W:0] diff;
        logic [PIX_W:0] neg;
        diff = {1'b0, a} - {1'b0, b};
        neg  = -diff;
        // The sign bit of the 9-bit difference selects the magnitude; the
        // magnitude always fits in 8 bits.
        return diff[PIX_W] ? neg[PIX_W-1:0] : diff[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/sad_accumulator.sv
// Per-candidate SAD accumulator.
// Ports:
//   clk, rst        clock / synchronous active-high reset
//   pv              a valid pixel pair is present on pix_cur / pix_ref
//   clear           zero the accumulator and the reject flag
//   pix_cur/pix_ref current-frame and reference-frame pixels
//   limit           early-termination threshold (running minimum SAD)
//   acc             registered accumulated SAD
//   acc_next        value acc takes at the next edge (lets the top capture the
//                   final SAD on the same edge the last pixel is added)
//   reject          candidate was frozen by early termination
// Build option: define SAD_EARLY_TERM_EN to freeze the accumulation once it
// reaches limit; otherwise every pixel is always accumulated.
module sad_accumulator
    import sad_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             pv,
    input  logic             clear,
    input  logic [PIX_W-1:0] pix_cur,
    input  logic [PIX_W-1:0] pix_ref,
    input  logic [SAD_W-1:0] limit,
    output logic [SAD_W-1:0] acc,
    output logic [SAD_W-1:0] acc_next,
    output logic             reject
);

    logic [SAD_W-1:0] acc_reg;
    logic             reject_reg;
    logic             reject_next;
    logic             freeze;

`ifdef SAD_EARLY_TERM_EN
    // Once the partial SAD can no longer beat the minimum it stops growing.
    // The first candidate sees limit = SAD_INIT, above any reachable SAD.
    assign freeze = reject_reg || (acc_reg >= limit);
`else
    logic unused_limit;
    assign unused_limit = ^limit;
    assign freeze       = 1'b0;
`endif

    always_comb begin
        acc_next    = acc_reg;
        reject_next = reject_reg;
        if (clear) begin
            acc_next    = '0;
            reject_next = 1'b0;
        end else if (pv) begin
            if (freeze) begin
                reject_next = 1'b1;
            end else begin
                acc_next = acc_reg + SAD_W'(abs_diff(pix_cur, pix_ref));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg    <= '0;
            reject_reg <= 1'b0;
        end else begin
            acc_reg    <= acc_next;
            reject_reg <= reject_next;
        end
    end

    assign acc    = acc_reg;
    assign reject = reject_reg;

endmodule

// File: rtl/sad_min_search.sv
// Full-search SAD engine: for each of NUM_CAND candidates, waits for both
// pixel FIFOs to be full, drains 256 pixel pairs, accumulates the SAD and
// keeps the minimum SAD and the index of the candidate that produced it.
// Ports:
//   clk, rst               clock / synchronous active-high reset
//   start                  pulse; begins a search when idle
//   full_1, full_2         FIFO full flags (current / reference)
//   data_out_1, data_out_2 FIFO read data, valid the cycle after rd
//   rd_1, rd_2             FIFO read strobes (identical)
//   busy                   search in progress
//   cand_sad, cand_valid   SAD of the last completed candidate + pulse
//   sad_min, best_idx      running minimum SAD and its candidate index
//   done                   pulse after the last candidate is compared
// Build option: SAD_EARLY_TERM_EN (see sad_accumulator).
module sad_min_search
    import sad_pkg::*;
#(
    parameter int NUM_CAND = 289,
    parameter int CAND_W   = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              full_1,
    input  logic              full_2,
    input  logic [PIX_W-1:0]  data_out_1,
    input  logic [PIX_W-1:0]  data_out_2,
    output logic              rd_1,
    output logic              rd_2,
    output logic              busy,
    output logic [SAD_W-1:0]  cand_sad,
    output logic              cand_valid,
    output logic [SAD_W-1:0]  sad_min,
    output logic [CAND_W-1:0] best_idx,
    output logic              done
);

    localparam logic [CAND_W-1:0] LAST_CAND = CAND_W'(NUM_CAND - 1);

    state_t            state_reg, state_next;
    logic [7:0]        pix_cnt_reg;
    logic [CAND_W-1:0] cand_idx_reg;
    logic              pv_reg;
    logic              rd_reg, busy_reg, cand_valid_reg, done_reg;
    logic              rd_next, busy_next, cand_valid_next, done_next;
    logic [SAD_W-1:0]  cand_sad_reg;
    logic [SAD_W-1:0]  sad_min_reg;
    logic [CAND_W-1:0] best_idx_reg;

    logic [SAD_W-1:0]  acc;
    logic [SAD_W-1:0]  acc_next;
    logic              reject;
    logic              accept_start;

    assign accept_start = (state_reg == ST_IDLE) && start;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:      if (start) state_next = ST_WAIT_FULL;
            ST_WAIT_FULL: if (full_1 && full_2) state_next = ST_READ;
            // The pixel counter wraps 255 -> 0 as READ ends: 256 reads, no gaps.
            ST_READ:      if (pix_cnt_reg == 8'd255) state_next = ST_DRAIN;
            ST_DRAIN:     state_next = ST_COMPARE;
            ST_COMPARE:   state_next = (cand_idx_reg == LAST_CAND) ? ST_DONE : ST_WAIT_FULL;
            ST_DONE:      state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    // Decoded from the next state so every strobe comes straight from a flop.
    always_comb begin
        rd_next         = (state_next == ST_READ);
        busy_next       = (state_next != ST_IDLE);
        cand_valid_next = (state_next == ST_COMPARE);
        done_next       = (state_next == ST_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_reg         <= 1'b0;
            busy_reg       <= 1'b0;
            cand_valid_reg <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            rd_reg         <= rd_next;
            busy_reg       <= busy_next;
            cand_valid_reg <= cand_valid_next;
            done_reg       <= done_next;
        end
    end

    // ---------------- counters and minimum tracking ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            pix_cnt_reg  <= '0;
            cand_idx_reg <= '0;
            pv_reg       <= 1'b0;
            cand_sad_reg <= '0;
            sad_min_reg  <= SAD_INIT;
            best_idx_reg <= '0;
        end else begin
            pv_reg      <= rd_reg;
            pix_cnt_reg <= (state_reg == ST_READ) ? pix_cnt_reg + 8'd1 : 8'd0;

            if (accept_start) begin
                cand_idx_reg <= '0;
                sad_min_reg  <= SAD_INIT;
                best_idx_reg <= '0;
            end

            // The last pixel is added on the DRAIN edge; capture the total on
            // that same edge so cand_sad is valid together with cand_valid.
            if (state_reg == ST_DRAIN) begin
                cand_sad_reg <= acc_next;
            end

            if (state_reg == ST_COMPARE) begin
                // Strict compare: ties keep the earlier candidate.
                if (!reject && (acc < sad_min_reg)) begin
                    sad_min_reg  <= acc;
                    best_idx_reg <= cand_idx_reg;
                end
                if (cand_idx_reg != LAST_CAND) begin
                    cand_idx_reg <= cand_idx_reg + 1'b1;
                end
            end
        end
    end

    sad_accumulator u_acc (
        .clk      (clk),
        .rst      (rst),
        .pv       (pv_reg),
        .clear    (state_reg == ST_WAIT_FULL),
        .pix_cur  (data_out_1),
        .pix_ref  (data_out_2),
        .limit    (sad_min_reg),
        .acc      (acc),
        .acc_next (acc_next),
        .reject   (reject)
    );

    assign rd_1       = rd_reg;
    assign rd_2       = rd_reg;
    assign busy       = busy_reg;
    assign cand_sad   = cand_sad_reg;
    assign cand_valid = cand_valid_reg;
    assign sad_min    = sad_min_reg;
    assign best_idx   = best_idx_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_sad_min_search.sv
// Bench for sad_min_search with NUM_CAND=3. A FIFO model serves per-candidate
// pixel patterns; expected results are queued when a search is launched and a
// monitor pops and compares them whenever cand_valid / done appear.
module tb_sad_min_search;

    localparam int NC = 3;
    localparam int CW = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          full_1 = 1'b0;
    logic          full_2 = 1'b0;
    logic [7:0]    data_out_1 = '0;
    logic [7:0]    data_out_2 = '0;
    logic          rd_1, rd_2, busy, cand_valid, done;
    logic [15:0]   cand_sad, sad_min;
    logic [CW-1:0] best_idx;

    always #5 clk = ~clk;

    sad_min_search #(.NUM_CAND(NC), .CAND_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .full_1     (full_1),
        .full_2     (full_2),
        .data_out_1 (data_out_1),
        .data_out_2 (data_out_2),
        .rd_1       (rd_1),
        .rd_2       (rd_2),
        .busy       (busy),
        .cand_sad   (cand_sad),
        .cand_valid (cand_valid),
        .sad_min    (sad_min),
        .best_idx   (best_idx),
        .done       (done)
    );

    int checks = 0;
    int errors = 0;

    typedef struct { int lo; int hi; }     cexp_t;
    typedef struct { int smin; int bidx; } dexp_t;
    cexp_t cand_q[$];
    dexp_t done_q[$];

    // Candidate pattern: cur pixel constant; first k_a pixels of the reference
    // are ref_a, the rest ref_b. exp_lo/exp_hi: hand-computed cand_sad range.
    int cur_v[NC], ref_a[NC], ref_b[NC], k_a[NC], exp_lo[NC], exp_hi[NC];
    int fifo_cand = 0, fifo_pix = 0, fill_timer = 0, fill_stall = 0;
    bit fill_active = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic set_cand(input int i, input int c, input int ra, input int rb,
                            input int k, input int lo, input int hi);
        cur_v[i] = c; ref_a[i] = ra; ref_b[i] = rb; k_a[i] = k;
        exp_lo[i] = lo; exp_hi[i] = hi;
    endtask

    task automatic arm_fifo(input int stall);
        fifo_cand   = 0;
        fifo_pix    = 0;
        fill_stall  = stall;
        fill_timer  = 0;
        fill_active = 1'b1;
    endtask

    // FIFO model: a read seen in cycle c puts the pixel on data_out in c+1;
    // full flags drop on the first read and refill after each 256-pixel block.
    initial begin : fifo_model
        bit rd_n;
        forever begin
            @(negedge clk);
            rd_n = rd_1;
            @(posedge clk);
            #1;
            if (rd_n && !rst && fifo_cand < NC) begin
                data_out_1 = 8'(cur_v[fifo_cand]);
                data_out_2 = 8'((fifo_pix < k_a[fifo_cand]) ? ref_a[fifo_cand] : ref_b[fifo_cand]);
                full_1 = 1'b0;
                full_2 = 1'b0;
                fifo_pix++;
                if (fifo_pix == 256) begin
                    fifo_pix = 0;
                    fifo_cand++;
                    if (fifo_cand < NC) begin
                        fill_active = 1'b1;
                        fill_timer  = 0;
                    end
                end
            end
            if (fill_active) begin
                fill_timer++;
                full_1 = 1'b1;
                if (fill_timer >= 1 + fill_stall) begin
                    full_2      = 1'b1;
                    fill_active = 1'b0;
                end
            end
        end
    end

    // Monitor: read-burst shape plus scoreboard for cand_valid / done.
    initial begin : monitor
        int run = 0;
        int neg_cyc = 0;
        int last_cv = -100;
        bit prev_full = 1'b0;
        cexp_t ce;
        dexp_t de;
        forever begin
            @(negedge clk);
            neg_cyc++;
            if (rst) begin
                run = 0;
            end else if (rd_1) begin
                if (run == 0) begin
                    check("rd_only_after_both_full", int'(prev_full), 1);
                    check("rd_2_matches_rd_1", int'(rd_2), 1);
                end
                run++;
            end else if (run > 0) begin
                check("rd_burst_length", run, 256);
                run = 0;
            end
            prev_full = full_1 && full_2;

            if (cand_valid) begin
                last_cv = neg_cyc;
                if (cand_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_cand_valid: got cand_sad %0d, expected no candidate", cand_sad);
                end else begin
                    ce = cand_q.pop_front();
                    check_range("cand_sad", int'(cand_sad), ce.lo, ce.hi);
                end
            end
            if (done) begin
                check("done_one_cycle_after_last_cand_valid", neg_cyc - last_cv, 1);
                if (done_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: got sad_min %0d, expected no done", sad_min);
                end else begin
                    de = done_q.pop_front();
                    check("sad_min", int'(sad_min), de.smin);
                    check("best_idx", int'(best_idx), de.bidx);
                end
            end
        end
    end

    task automatic run_search(input int stall, input bit measure, input bit poke,
                              input int smin, input int bidx);
        int  k;
        bit  got_cv;
        for (int i = 0; i < NC; i++) cand_q.push_back('{exp_lo[i], exp_hi[i]});
        done_q.push_back('{smin, bidx});
        arm_fifo(stall);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (measure) check("busy_after_start", int'(busy), 1);
        k = 1;
        got_cv = 1'b0;
        while (k < 3000 && !done) begin
            if (cand_valid && !got_cv) begin
                got_cv = 1'b1;
                if (measure) check("first_cand_valid_latency", k, 259);
            end
            if (poke && k == 100) start = 1'b1;
            if (poke && k == 101) start = 1'b0;
            @(negedge clk);
            k++;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL done_timeout: got no done after %0d cycles, expected done", k);
            cand_q.delete();
            done_q.delete();
        end else if (poke) begin
            start = 1'b1;            // sampled while DONE: must be ignored
            @(negedge clk);
            start = 1'b0;
            @(negedge clk);
            check("start_on_done_ignored", int'(busy), 0);
        end
        repeat (2) @(negedge clk);
        check("scoreboard_drained", cand_q.size() + done_q.size(), 0);
    endtask

    task automatic check_reset_values();
        check("rst_rd", int'(rd_1), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_cand_sad", int'(cand_sad), 0);
        check("rst_cand_valid", int'(cand_valid), 0);
        check("rst_sad_min", int'(sad_min), 16'hFFFF);
        check("rst_best_idx", int'(best_idx), 0);
        check("rst_done", int'(done), 0);
    endtask

    initial begin : sequencer
        repeat (3) @(negedge clk);
        check_reset_values();
        rst = 1'b0;
        @(negedge clk);

        // Basic: 0, 2560, 2560 -> min 0 at index 0; start poked while busy and on DONE.
        set_cand(0, 100, 100, 100, 256, 0, 0);
        set_cand(1, 100, 110, 110, 256, 2560, 2560);
        set_cand(2, 100, 90, 90, 256, 2560, 2560);
        run_search(0, 1'b1, 1'b1, 0, 0);

        // Ties: 500, 300, 300 -> earlier of the tied candidates wins.
        set_cand(0, 100, 105, 100, 100, 500, 500);
        set_cand(1, 100, 97, 100, 100, 300, 300);
        set_cand(2, 100, 103, 100, 100, 300, 300);
        run_search(0, 1'b0, 1'b0, 300, 1);

        // Extremes: 65280 both directions, then 0.
        set_cand(0, 255, 0, 0, 256, 65280, 65280);
        set_cand(1, 0, 255, 255, 256, 65280, 65280);
        set_cand(2, 7, 7, 7, 256, 0, 0);
        run_search(0, 1'b0, 1'b0, 0, 2);

        // Stalled fill: full_2 lags full_1 by 20 cycles on every candidate.
        set_cand(0, 50, 60, 60, 256, 2560, 2560);
        set_cand(1, 50, 52, 52, 256, 512, 512);
        set_cand(2, 50, 51, 51, 256, 256, 256);
        run_search(20, 1'b0, 1'b0, 256, 2);

        // Reset in the middle of READ, then a clean search.
        set_cand(0, 30, 25, 25, 256, 1280, 1280);
        set_cand(1, 30, 31, 30, 128, 128, 128);
        set_cand(2, 30, 40, 40, 256, 2560, 2560);
        arm_fifo(0);
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        check("rd_high_before_reset", int'(rd_1), 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_search(0, 1'b1, 1'b0, 128, 1);

        // 300, 5000, 600: losers may be frozen early, winner is the same.
`ifdef SAD_EARLY_TERM_EN
        set_cand(0, 100, 103, 100, 100, 300, 300);
        set_cand(1, 100, 125, 100, 200, 300, 4999);
        set_cand(2, 100, 106, 100, 100, 300, 599);
`else
        set_cand(0, 100, 103, 100, 100, 300, 300);
        set_cand(1, 100, 125, 100, 200, 5000, 5000);
        set_cand(2, 100, 106, 100, 100, 600, 600);
`endif
        run_search(0, 1'b0, 1'b0, 300, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
